// File: rtl/qspi_seq_pkg.sv
// qspi_seq_pkg: flash opcodes, host request encoding, FSM state / sequence step types and the
// per-step qspi_master transaction descriptor shared by the sequencer files.
package qspi_seq_pkg;

   localparam logic [7:0] OpcWren     = 8'h06;
   localparam logic [7:0] OpcRdsr     = 8'h05;
   localparam logic [7:0] OpcQuadRead = 8'h6B;
   localparam logic [7:0] OpcQuadPp   = 8'h32;
   localparam logic [7:0] OpcSe4k     = 8'h20;

   typedef enum logic [1:0] {
      ReqRead    = 2'd0,
      ReqProgram = 2'd1,
      ReqErase4k = 2'd2,
      ReqRsvd    = 2'd3
   } req_op_e;

   typedef enum logic [3:0] {
      StInit,
      StIdle,
      StIssue,
      StWaitStart,
      StWaitDone,
      StXfer,
      StGap,
      StDone,
      StErr
   } state_e;

   typedef enum logic [2:0] {
      StepWren,
      StepRead,
      StepProg,
      StepErase,
      StepPoll
   } step_e;

   // Everything qspi_master needs for one transaction, driven only in the issue cycle.
   typedef struct packed {
      logic [31:0] cmd;
      logic [5:0]  cmd_len;
      logic [31:0] addr;
      logic [5:0]  addr_len;
      logic [15:0] dummy_len;
      logic [15:0] data_len;
      logic        single_write;
      logic        single_read;
      logic        quad_write;
      logic        quad_read;
   } seq_desc_t;

   function automatic seq_desc_t step_desc(input step_e step, input logic [23:0] addr,
                                            input logic [15:0] dummy);
      seq_desc_t d;
      d = '0;
      d.cmd_len = 6'd8;
      case (step)
         StepWren: begin
            d.cmd          = {OpcWren, 24'h0};
            d.single_write = 1'b1;
         end
         StepRead: begin
            d.cmd       = {OpcQuadRead, 24'h0};
            d.addr      = {addr, 8'h0};
            d.addr_len  = 6'd24;
            d.dummy_len = dummy;
            d.data_len  = 16'd32;
            d.quad_read = 1'b1;
         end
         StepProg: begin
            d.cmd        = {OpcQuadPp, 24'h0};
            d.addr       = {addr, 8'h0};
            d.addr_len   = 6'd24;
            d.data_len   = 16'd32;
            d.quad_write = 1'b1;
         end
         StepErase: begin
            d.cmd          = {OpcSe4k, 24'h0};
            d.addr         = {addr, 8'h0};
            d.addr_len     = 6'd24;
            d.single_write = 1'b1;
         end
         StepPoll: begin
            d.cmd         = {OpcRdsr, 24'h0};
            d.data_len    = 16'd8;
            d.single_read = 1'b1;
         end
         default: d = '0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/qspi_flash_sequencer_if.sv
// Host-side request/response bus of the flash sequencer.
interface qspi_flash_sequencer_if;
   import qspi_seq_pkg::*;

   logic        req_valid;
   logic        req_ready;
   req_op_e     req_op;
   logic [23:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        busy;

   modport master (
      output req_valid, req_op, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
   );

endinterface

// File: rtl/qspi_seq_issue.sv
// qspi_seq_issue: drives one qspi_master transaction descriptor for the single issue cycle and
// tracks start (m_state leaves 0), done (m_state back at 0) and the start timeout.
module qspi_seq_issue
   import qspi_seq_pkg::*;
(
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       i_issue,
   input  logic       i_wait_start,
   input  seq_desc_t  i_desc,
   input  logic [2:0] i_m_state,
   output logic       o_started,
   output logic       o_done,
   output logic       o_timeout,
   output seq_desc_t  o_desc
);

   // Master must leave idle within four clocks of the issue cycle.
   localparam logic [2:0] StartLast = 3'd3;

   logic [2:0] r_start_cnt;
   logic [2:0] w_start_cnt_nxt;

   // Fields and strobe exist only in the issue cycle; zero otherwise.
   always_comb begin
      o_desc    = i_issue ? i_desc : '0;
      o_started = (i_m_state != 3'd0);
      o_done    = (i_m_state == 3'd0);
      o_timeout = i_wait_start && !o_started && (r_start_cnt == StartLast);
      w_start_cnt_nxt = r_start_cnt;
      if (i_issue) begin
         w_start_cnt_nxt = 3'd0;
      end else if (i_wait_start && (r_start_cnt != 3'd7)) begin
         w_start_cnt_nxt = r_start_cnt + 3'd1;
      end
   end

   // Start-wait cycle counter.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_start_cnt <= 3'd0;
      end else begin
         r_start_cnt <= w_start_cnt_nxt;
      end
   end

endmodule

// File: rtl/qspi_flash_sequencer.sv
// qspi_flash_sequencer: turns host READ / PROGRAM / ERASE_4K requests into complete qspi_master
// command sequences (divider setup, WREN, op, status polling) and reports completion.
module qspi_flash_sequencer
   import qspi_seq_pkg::*;
#(
   parameter logic [7:0]  CLK_DIV    = 8'd1,
   parameter logic [15:0] DUMMY_CYC  = 16'd8,
   parameter int unsigned POLL_GAP   = 16,
   parameter int unsigned POLL_LIMIT = 4096
) (
   input  logic                         i_clock,
   input  logic                         i_reset,
   qspi_flash_sequencer_if.slave        io_host,
   output logic [7:0]                   o_m_clk_div,
   output logic                         o_m_clk_div_valid,
   output logic [31:0]                  o_m_cmd,
   output logic [5:0]                   o_m_cmd_len,
   output logic [31:0]                  o_m_addr,
   output logic [5:0]                   o_m_addr_len,
   output logic [15:0]                  o_m_dummy_len,
   output logic [15:0]                  o_m_data_len,
   output logic                         o_m_single_write,
   output logic                         o_m_single_read,
   output logic                         o_m_quad_write,
   output logic                         o_m_quad_read,
   output logic                         o_m_tx_valid,
   output logic [31:0]                  o_m_tx_bits,
   input  logic                         i_m_tx_ready,
   output logic                         o_m_rx_ready,
   input  logic                         i_m_rx_valid,
   input  logic [31:0]                  i_m_rx_bits,
   input  logic [2:0]                   i_m_state
);

   localparam logic [12:0] PollLimit = 13'(POLL_LIMIT);
   localparam logic [15:0] GapLast   = 16'(POLL_GAP - 1);

   state_e      r_state,    w_state_nxt;
   step_e       r_step,     w_step_nxt;
   req_op_e     r_op,       w_op_nxt;
   logic [23:0] r_addr,     w_addr_nxt;
   logic [31:0] r_wdata,    w_wdata_nxt;
   logic [31:0] r_rdata,    w_rdata_nxt;
   logic        r_wip,      w_wip_nxt;
   logic [12:0] r_poll_cnt, w_poll_cnt_nxt;
   logic [15:0] r_gap_cnt,  w_gap_cnt_nxt;

   logic        w_issue, w_wait_start, w_started, w_done, w_timeout;
   logic        w_req_ready, w_rsp_valid, w_rsp_err, w_clk_div_valid;
   logic        w_tx_valid, w_rx_ready, w_needs_xfer;
   logic [12:0] w_poll_inc;
   seq_desc_t   w_desc_sel, w_desc_out;

   assign w_desc_sel   = step_desc(r_step, r_addr, DUMMY_CYC);
   assign w_needs_xfer = (r_step == StepRead) || (r_step == StepProg) || (r_step == StepPoll);
   assign w_poll_inc   = (r_poll_cnt == 13'h1fff) ? r_poll_cnt : r_poll_cnt + 13'd1;

   qspi_seq_issue u_issue (
      .i_clock      (i_clock),
      .i_reset      (i_reset),
      .i_issue      (w_issue),
      .i_wait_start (w_wait_start),
      .i_desc       (w_desc_sel),
      .i_m_state    (i_m_state),
      .o_started    (w_started),
      .o_done       (w_done),
      .o_timeout    (w_timeout),
      .o_desc       (w_desc_out)
   );

   // Next-state and output decode of the sequence FSM.
   always_comb begin
      w_state_nxt     = r_state;
      w_step_nxt      = r_step;
      w_op_nxt        = r_op;
      w_addr_nxt      = r_addr;
      w_wdata_nxt     = r_wdata;
      w_rdata_nxt     = r_rdata;
      w_wip_nxt       = r_wip;
      w_poll_cnt_nxt  = r_poll_cnt;
      w_gap_cnt_nxt   = r_gap_cnt;
      w_issue         = 1'b0;
      w_wait_start    = 1'b0;
      w_req_ready     = 1'b0;
      w_rsp_valid     = 1'b0;
      w_rsp_err       = 1'b0;
      w_clk_div_valid = 1'b0;
      w_tx_valid      = 1'b0;
      w_rx_ready      = 1'b0;
      unique case (r_state)
         StInit: begin
            // Held in INIT while reset is high so the divider pulse follows reset release.
            w_clk_div_valid = !i_reset;
            w_state_nxt     = StIdle;
         end
         StIdle: begin
            w_req_ready = 1'b1;
            if (io_host.req_valid) begin
               w_op_nxt       = io_host.req_op;
               w_addr_nxt     = io_host.req_addr;
               w_wdata_nxt    = io_host.req_wdata;
               w_poll_cnt_nxt = 13'd0;
               case (io_host.req_op)
                  ReqRead: begin
                     w_step_nxt  = StepRead;
                     w_state_nxt = StIssue;
                  end
                  ReqProgram, ReqErase4k: begin
                     w_step_nxt  = StepWren;
                     w_state_nxt = StIssue;
                  end
                  default: w_state_nxt = StErr;
               endcase
            end
         end
         StIssue: begin
            w_issue     = 1'b1;
            w_state_nxt = StWaitStart;
         end
         StWaitStart: begin
            w_wait_start = 1'b1;
            if (w_started) begin
               w_state_nxt = w_needs_xfer ? StXfer : StWaitDone;
            end else if (w_timeout) begin
               w_state_nxt = StErr;
            end
         end
         StXfer: begin
            if (r_step == StepProg) begin
               w_tx_valid = 1'b1;
               if (i_m_tx_ready) begin
                  w_state_nxt = StWaitDone;
               end
            end else begin
               w_rx_ready = 1'b1;
               if (i_m_rx_valid) begin
                  if (r_step == StepRead) begin
                     w_rdata_nxt = i_m_rx_bits;
                  end else begin
                     w_wip_nxt = i_m_rx_bits[0];
                  end
                  w_state_nxt = StWaitDone;
               end
            end
         end
         StWaitDone: begin
            if (w_done) begin
               case (r_step)
                  StepWren: begin
                     w_step_nxt  = (r_op == ReqProgram) ? StepProg : StepErase;
                     w_state_nxt = StIssue;
                  end
                  StepProg, StepErase: begin
                     w_step_nxt     = StepPoll;
                     w_poll_cnt_nxt = 13'd0;
                     w_state_nxt    = StIssue;
                  end
                  StepPoll: begin
                     w_poll_cnt_nxt = w_poll_inc;
                     if (!r_wip) begin
                        w_state_nxt = StDone;
                     end else if (w_poll_inc >= PollLimit) begin
                        w_state_nxt = StErr;
                     end else begin
                        w_gap_cnt_nxt = 16'd0;
                        w_state_nxt   = StGap;
                     end
                  end
                  default: w_state_nxt = StDone;
               endcase
            end
         end
         StGap: begin
            w_gap_cnt_nxt = r_gap_cnt + 16'd1;
            if (r_gap_cnt >= GapLast) begin
               w_state_nxt = StIssue;
            end
         end
         StDone: begin
            w_rsp_valid = 1'b1;
            w_state_nxt = StIdle;
         end
         StErr: begin
            w_rsp_valid = 1'b1;
            w_rsp_err   = 1'b1;
            w_state_nxt = StIdle;
         end
         default: w_state_nxt = StInit;
      endcase
   end

   // State and request context registers; reset aborts any sequence in flight.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state    <= StInit;
         r_step     <= StepWren;
         r_op       <= ReqRead;
         r_addr     <= 24'h0;
         r_wdata    <= 32'h0;
         r_rdata    <= 32'h0;
         r_wip      <= 1'b0;
         r_poll_cnt <= 13'd0;
         r_gap_cnt  <= 16'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_step     <= w_step_nxt;
         r_op       <= w_op_nxt;
         r_addr     <= w_addr_nxt;
         r_wdata    <= w_wdata_nxt;
         r_rdata    <= w_rdata_nxt;
         r_wip      <= w_wip_nxt;
         r_poll_cnt <= w_poll_cnt_nxt;
         r_gap_cnt  <= w_gap_cnt_nxt;
      end
   end

   assign io_host.req_ready = w_req_ready;
   assign io_host.rsp_valid = w_rsp_valid;
   assign io_host.rsp_err   = w_rsp_err;
   assign io_host.rsp_rdata = r_rdata;
   assign io_host.busy      = (r_state != StInit) && (r_state != StIdle);

   assign o_m_clk_div       = w_clk_div_valid ? CLK_DIV : 8'h0;
   assign o_m_clk_div_valid = w_clk_div_valid;
   assign o_m_cmd           = w_desc_out.cmd;
   assign o_m_cmd_len       = w_desc_out.cmd_len;
   assign o_m_addr          = w_desc_out.addr;
   assign o_m_addr_len      = w_desc_out.addr_len;
   assign o_m_dummy_len     = w_desc_out.dummy_len;
   assign o_m_data_len      = w_desc_out.data_len;
   assign o_m_single_write  = w_desc_out.single_write;
   assign o_m_single_read   = w_desc_out.single_read;
   assign o_m_quad_write    = w_desc_out.quad_write;
   assign o_m_quad_read     = w_desc_out.quad_read;
   assign o_m_tx_valid      = w_tx_valid;
   assign o_m_tx_bits       = w_tx_valid ? r_wdata : 32'h0;
   assign o_m_rx_ready      = w_rx_ready;

endmodule

// File: tb/tb_qspi_flash_sequencer.sv
// Bench for qspi_flash_sequencer: behavioural qspi_master + flash model, scoreboard of host
// responses checked by an independent monitor, plus directed checks on the flash traffic.
module tb_qspi_flash_sequencer;
   import qspi_seq_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   qspi_flash_sequencer_if host ();

   logic [7:0]  m_clk_div;
   logic        m_clk_div_valid;
   logic [31:0] m_cmd, m_addr, m_tx_bits;
   logic [5:0]  m_cmd_len, m_addr_len;
   logic [15:0] m_dummy_len, m_data_len;
   logic        m_sw, m_sr, m_qw, m_qr, m_tx_valid, m_rx_ready;
   logic        m_tx_ready = 1'b0;
   logic        m_rx_valid = 1'b0;
   logic [31:0] m_rx_bits  = 32'h0;
   logic [2:0]  m_state    = 3'd0;

   qspi_flash_sequencer #(
      .CLK_DIV    (8'd1),
      .DUMMY_CYC  (16'd8),
      .POLL_GAP   (4),
      .POLL_LIMIT (4)
   ) dut (
      .i_clock           (clk),
      .i_reset           (rst),
      .io_host           (host),
      .o_m_clk_div       (m_clk_div),
      .o_m_clk_div_valid (m_clk_div_valid),
      .o_m_cmd           (m_cmd),
      .o_m_cmd_len       (m_cmd_len),
      .o_m_addr          (m_addr),
      .o_m_addr_len      (m_addr_len),
      .o_m_dummy_len     (m_dummy_len),
      .o_m_data_len      (m_data_len),
      .o_m_single_write  (m_sw),
      .o_m_single_read   (m_sr),
      .o_m_quad_write    (m_qw),
      .o_m_quad_read     (m_qr),
      .o_m_tx_valid      (m_tx_valid),
      .o_m_tx_bits       (m_tx_bits),
      .i_m_tx_ready      (m_tx_ready),
      .o_m_rx_ready      (m_rx_ready),
      .i_m_rx_valid      (m_rx_valid),
      .i_m_rx_bits       (m_rx_bits),
      .i_m_state         (m_state)
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
   endtask

   // ---------------- qspi_master + flash model ----------------
   logic [7:0]  op_log[$];
   logic [3:0]  strb_log[$];
   logic [15:0] dummy_log[$];
   logic [31:0] addr_log[$];
   logic [31:0] fmem [logic [23:0]];
   int          wip_cnt   = 0;
   logic        wip_stuck = 1'b0;
   logic        mm_active = 1'b0;
   int          mm_cnt    = 0;
   logic [7:0]  mm_op     = 8'h0;
   logic [23:0] mm_addr   = 24'h0;
   int          mstate_cycles = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_state    <= 3'd0;
         mm_active  <= 1'b0;
         m_rx_valid <= 1'b0;
         m_tx_ready <= 1'b0;
      end else if (!mm_active) begin
         if (m_sw || m_sr || m_qw || m_qr) begin
            op_log.push_back(m_cmd[31:24]);
            strb_log.push_back({m_qr, m_qw, m_sr, m_sw});
            dummy_log.push_back(m_dummy_len);
            addr_log.push_back(m_addr);
            if (m_cmd[31:24] == 8'h32 || m_cmd[31:24] == 8'h20) wip_cnt = 2;
            mm_active <= 1'b1;
            mm_cnt    <= 0;
            mm_op     <= m_cmd[31:24];
            mm_addr   <= m_addr[31:8];
            m_state   <= 3'd2;
         end
      end else begin
         mm_cnt <= mm_cnt + 1;
         if (mm_cnt == 1) begin
            if (mm_op == 8'h6B) begin
               m_rx_valid <= 1'b1;
               m_rx_bits  <= fmem.exists(mm_addr) ? fmem[mm_addr] : 32'hFFFF_FFFF;
            end else if (mm_op == 8'h05) begin
               m_rx_valid <= 1'b1;
               m_rx_bits  <= {31'h0, (wip_stuck || wip_cnt != 0)};
               if (wip_cnt != 0) wip_cnt = wip_cnt - 1;
            end else if (mm_op == 8'h32) begin
               m_tx_ready <= 1'b1;
            end
         end
         if (m_rx_valid && m_rx_ready) m_rx_valid <= 1'b0;
         if (m_tx_ready && m_tx_valid) begin
            m_tx_ready <= 1'b0;
            fmem[mm_addr] = m_tx_bits;
         end
         if (mm_cnt >= 4 && !m_rx_valid && !m_tx_ready) begin
            m_state   <= 3'd0;
            mm_active <= 1'b0;
         end
      end
   end

   function automatic int count_op(input logic [7:0] op);
      int c = 0;
      foreach (op_log[i]) if (op_log[i] == op) c++;
      return c;
   endfunction

   function automatic logic any_out();
      return |{host.req_ready, host.rsp_valid, host.rsp_err, host.rsp_rdata, host.busy,
               m_clk_div, m_clk_div_valid, m_cmd, m_cmd_len, m_addr, m_addr_len,
               m_dummy_len, m_data_len, m_sw, m_sr, m_qw, m_qr, m_tx_valid, m_tx_bits,
               m_rx_ready};
   endfunction

   // ---------------- scoreboard + monitors ----------------
   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
      logic        chk;
   } exp_t;

   exp_t sb_q[$];
   int   rsp_cnt    = 0;
   int   div_pulses = 0;
   int   busy_low   = 0;
   logic trk_busy   = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      if (!rst && host.rsp_valid) begin
         rsp_cnt++;
         if (sb_q.size() == 0) begin
            check("rsp_expected_pending", 64'(sb_q.size()), 64'd1);
         end else begin
            e = sb_q.pop_front();
            check("rsp_err", 64'(host.rsp_err), 64'(e.err));
            if (e.chk) check("rsp_rdata", 64'(host.rsp_rdata), 64'(e.rdata));
         end
      end
      if (m_state != 3'd0) mstate_cycles++;
   end

   always @(posedge clk) begin
      if (m_clk_div_valid) begin
         div_pulses++;
         check("clk_div_value", 64'(m_clk_div), 64'd1);
      end
      #1;
      if (trk_busy) begin
         if (!host.busy) busy_low++;
         if (host.rsp_valid) trk_busy = 1'b0;
      end
   end

   // ---------------- stimulus ----------------
   task automatic send_req(input logic [1:0] op, input logic [23:0] addr, input logic [31:0] wd,
                           input logic e_err, input logic [31:0] e_rd, input logic e_chk);
      int   n;
      exp_t e;
      @(negedge clk);
      host.req_valid = 1'b1;
      host.req_op    = req_op_e'(op);
      host.req_addr  = addr;
      host.req_wdata = wd;
      n = 0;
      while (!host.req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("req_accepted", 64'(host.req_ready), 64'd1);
      if (host.req_ready) begin
         e.err = e_err; e.rdata = e_rd; e.chk = e_chk;
         sb_q.push_back(e);
         trk_busy = 1'b1;
      end
      @(negedge clk);
      host.req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input string name);
      int n = 0;
      while (sb_q.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      #1;
      check(name, 64'(sb_q.size()), 64'd0);
   endtask

   initial begin
      int rc, lg, ms, n;
      host.req_valid = 1'b0;
      host.req_op    = ReqRead;
      host.req_addr  = 24'h0;
      host.req_wdata = 32'h0;

      // Reset and INIT
      repeat (3) @(negedge clk);
      check("reset_outputs_zero", 64'(any_out()), 64'd0);
      rst = 1'b0;
      #1;
      check("init_div_valid", 64'(m_clk_div_valid), 64'd1);
      check("init_div", 64'(m_clk_div), 64'd1);
      check("init_ready_low", 64'(host.req_ready), 64'd0);
      @(negedge clk);
      check("idle_ready", 64'(host.req_ready), 64'd1);
      check("div_valid_once", 64'(m_clk_div_valid), 64'd0);

      // PROGRAM 0x000600 <- 0x12345678
      op_log.delete(); strb_log.delete(); dummy_log.delete(); addr_log.delete();
      send_req(2'd1, 24'h000600, 32'h1234_5678, 1'b0, 32'h0, 1'b0);
      wait_rsp("prog_rsp_arrived");
      check("prog_n_ops", 64'(op_log.size()), 64'd5);
      check("prog_op0_wren", 64'(op_log[0]), 64'h06);
      check("prog_op1_pp", 64'(op_log[1]), 64'h32);
      check("prog_op1_quad_write", 64'(strb_log[1]), 64'b0100);
      check("prog_n_polls", 64'(count_op(8'h05)), 64'd3);
      check("prog_flash_data", 64'(fmem[24'h000600]), 64'h1234_5678);
      check("prog_busy_held", 64'(busy_low), 64'd0);

      // READ 0x000600
      op_log.delete(); strb_log.delete(); dummy_log.delete(); addr_log.delete();
      send_req(2'd0, 24'h000600, 32'h0, 1'b0, 32'h1234_5678, 1'b1);
      wait_rsp("read_rsp_arrived");
      check("read_n_ops", 64'(op_log.size()), 64'd1);
      check("read_opcode", 64'(op_log[0]), 64'h6B);
      check("read_dummy", 64'(dummy_log[0]), 64'd8);
      check("read_addr", 64'(addr_log[0]), 64'h0006_0000);
      check("read_quad_strobe", 64'(strb_log[0]), 64'b1000);

      // ERASE with WIP stuck: poll limit error
      op_log.delete(); strb_log.delete(); dummy_log.delete(); addr_log.delete();
      wip_stuck = 1'b1;
      send_req(2'd2, 24'h002000, 32'h0, 1'b1, 32'h0, 1'b0);
      wait_rsp("erase_rsp_arrived");
      wip_stuck = 1'b0;
      check("erase_op1", 64'(op_log[1]), 64'h20);
      check("erase_poll_limit", 64'(count_op(8'h05)), 64'd4);

      // Reserved op: error without flash traffic
      lg = op_log.size();
      ms = mstate_cycles;
      rc = rsp_cnt;
      send_req(2'd3, 24'h0, 32'h0, 1'b1, 32'h0, 1'b0);
      for (int i = 0; i < 3 && rsp_cnt == rc; i++) @(negedge clk);
      #1;
      check("rsvd_rsp_latency", 64'(rsp_cnt - rc), 64'd1);
      check("rsvd_no_strobe", 64'(op_log.size()), 64'(lg));
      repeat (3) @(negedge clk);
      check("rsvd_mstate_idle", 64'(mstate_cycles), 64'(ms));
      wait_rsp("rsvd_rsp_arrived");

      // Reset during PROGRAM status poll
      op_log.delete(); strb_log.delete(); dummy_log.delete(); addr_log.delete();
      send_req(2'd1, 24'h001000, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0);
      n = 0;
      while (count_op(8'h05) == 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("mid_poll_reached", 64'(count_op(8'h05) != 0), 64'd1);
      rst = 1'b1;
      sb_q.delete();
      trk_busy = 1'b0;
      rc = rsp_cnt;
      @(negedge clk);
      check("abort_outputs_zero", 64'(any_out()), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("reinit_div_valid", 64'(m_clk_div_valid), 64'd1);
      @(negedge clk);
      check("reinit_ready", 64'(host.req_ready), 64'd1);
      check("abort_no_rsp", 64'(rsp_cnt), 64'(rc));
      check("div_pulse_count", 64'(div_pulses), 64'd2);

      // READ back data programmed before the abort
      send_req(2'd0, 24'h001000, 32'h0, 1'b0, 32'hCAFE_F00D, 1'b1);
      wait_rsp("read2_rsp_arrived");
      check("busy_held_all", 64'(busy_low), 64'd0);

      repeat (5) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
